// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module  : keypad_pkg
// Brief   : Shared sizes, key vector type and one-hot helper for the keypad scanner.
// Revision: 1.0
// ============================================================================
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = 16;

    typedef logic [NUM_KEYS-1:0] key_vec_t;

    function automatic logic is_one_hot(input key_vec_t v);
        return ($countones(v) == 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// Module  : keypad_debounce
// Brief   : Accepts a full-matrix snapshot once it repeats for DEBOUNCE_SCANS scans.
// Revision: 1.0
// ============================================================================
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     scan_done_i,
    input  key_vec_t snapshot_i,
    output key_vec_t stable_o
);

    localparam int                CNT_W      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]  CNT_ACCEPT = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [CNT_W-1:0] count_q, count_d;
    key_vec_t         prev_q, prev_d;
    key_vec_t         stable_q, stable_d;
    logic             same;
    logic             accept;

    always_comb begin
        same     = (snapshot_i == prev_q);
        // count_q + 1 >= DEBOUNCE_SCANS, written to avoid widening the counter
        accept   = same && (count_q >= CNT_ACCEPT);
        count_d  = count_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        if (scan_done_i) begin
            prev_d = snapshot_i;
            if (!same) begin
                count_d = '0;
            end else if (count_q != CNT_MAX) begin
                count_d = count_q + 1'b1;
            end
            if (accept) begin
                stable_d = snapshot_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            prev_q   <= '0;
            stable_q <= '0;
        end else begin
            count_q  <= count_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module  : keypad_scanner
// Brief   : 4x4 keypad column scan, debounce, one-hot filter and press strobe.
//           Define KEYPAD_SYNC_EN to add a two-flop synchronizer on row.
// Revision: 1.0
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output key_vec_t            buttons,
    output logic                press
);

    localparam int                 SLOT_W    = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [1:0]         COL_LAST  = 2'(NUM_COLS - 1);

    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [1:0]          index_q, index_d;
    key_vec_t            snap_q, snap_d;
    key_vec_t            buttons_q, buttons_d;
    logic                press_q, press_d;
    key_vec_t            stable;
    logic [NUM_ROWS-1:0] row_s;
    logic                slot_last;
    logic                scan_done;

`ifdef KEYPAD_SYNC_EN
    logic [NUM_ROWS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= row;
            sync2_q <= sync1_q;
        end
    end

    assign row_s = sync2_q;
`else
    assign row_s = row;
`endif

    always_comb begin
        slot_last = (slot_q == SLOT_LAST);
        scan_done = slot_last && (index_q == COL_LAST);
        slot_d    = slot_last ? '0 : slot_q + 1'b1;
        index_d   = slot_last ? index_q + 1'b1 : index_q;
        // The debouncer sees the snapshot including the column sampled this edge
        snap_d    = snap_q;
        if (slot_last) begin
            snap_d[{index_q, 2'b00} +: NUM_ROWS] = ~row_s;
        end
        buttons_d = is_one_hot(stable) ? stable : '0;
        press_d   = (buttons_d != '0) && (buttons_d != buttons_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q    <= '0;
            index_q   <= '0;
            snap_q    <= '0;
            buttons_q <= '0;
            press_q   <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            index_q   <= index_d;
            snap_q    <= snap_d;
            buttons_q <= buttons_d;
            press_q   <= press_d;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .scan_done_i (scan_done),
        .snapshot_i  (snap_d),
        .stable_o    (stable)
    );

    assign col     = ~(4'b0001 << index_q);
    assign buttons = buttons_q;
    assign press   = press_q;

endmodule
`default_nettype wire
